// File: rtl/vending_machine_multi.sv
// Multi-product coin vendor: credit accumulation, priced select, dispenser handshake, greedy change.
// Optional sales counter output enabled by defining VEND_SALES_CNT_EN.
module vending_machine_multi #(
    parameter int NUM_ITEMS  = 4,
    parameter int CREDIT_W   = 6,
    parameter int MAX_CREDIT = 20,
    parameter logic [NUM_ITEMS*CREDIT_W-1:0] PRICES = {NUM_ITEMS{CREDIT_W'(4)}}
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 nickle_i,
    input  logic                 dime_i,
    input  logic                 quarter_i,
    input  logic [NUM_ITEMS-1:0] sel_i,
    input  logic                 cancel_i,
    input  logic                 vend_ready_i,
    output logic [NUM_ITEMS-1:0] item_valid_o,
    output logic                 chg_nickle_o,
    output logic                 chg_dime_o,
    output logic                 chg_quarter_o,
    output logic                 coin_reject_o,
    output logic                 sel_err_o,
    output logic [CREDIT_W-1:0]  credit_o,
    output logic                 busy_o
`ifdef VEND_SALES_CNT_EN
    ,
    output logic [15:0]          sales_cnt_o
`endif
);

    // Prices are sliced to CREDIT_W bits, so only the ceiling and coin values need checking.
    if (MAX_CREDIT > (2**CREDIT_W) - 1) begin : g_bad_max
        $error("MAX_CREDIT does not fit in CREDIT_W bits");
    end
    if (CREDIT_W < 3) begin : g_bad_width
        $error("CREDIT_W must hold a quarter (5 units)");
    end

    localparam int SUM_W = CREDIT_W + 3;

    typedef enum logic [1:0] {S_IDLE, S_CREDIT, S_VEND, S_CHANGE} state_t;

    state_t                 state_q, state_d;
    logic [CREDIT_W-1:0]    credit_d;
    logic [NUM_ITEMS-1:0]   item_d;
    logic [2:0]             chg_d;        // {quarter, dime, nickel}
    logic                   reject_d;
    logic                   sel_err_d;
    logic                   sale;

    logic [2:0]             coin_vec;
    logic                   coin_any, coin_multi, coin_ok;
    logic [CREDIT_W-1:0]    coin_val, credit_upd;
    logic [SUM_W-1:0]       coin_sum;
    logic                   sel_any, sel_onehot, afford;
    logic [CREDIT_W-1:0]    sel_price, vend_price, remain;
    logic [NUM_ITEMS-1:0][CREDIT_W-1:0] sel_masked, vend_masked;

    function automatic logic [2:0] pick_coin(input logic [CREDIT_W-1:0] r);
        if (r >= CREDIT_W'(5))      pick_coin = 3'b100;
        else if (r >= CREDIT_W'(2)) pick_coin = 3'b010;
        else if (r != '0)           pick_coin = 3'b001;
        else                        pick_coin = 3'b000;
    endfunction

    function automatic logic [CREDIT_W-1:0] coin_units(input logic [2:0] c);
        case (c)
            3'b100:  coin_units = CREDIT_W'(5);
            3'b010:  coin_units = CREDIT_W'(2);
            3'b001:  coin_units = CREDIT_W'(1);
            default: coin_units = '0;
        endcase
    endfunction

    for (genvar i = 0; i < NUM_ITEMS; i++) begin : g_item
        localparam logic [CREDIT_W-1:0] PRICE = PRICES[i*CREDIT_W +: CREDIT_W];
        assign sel_masked[i]  = sel_i[i]        ? PRICE : '0;
        assign vend_masked[i] = item_valid_o[i] ? PRICE : '0;
    end

    always_comb begin
        sel_price  = '0;
        vend_price = '0;
        for (int i = 0; i < NUM_ITEMS; i++) begin
            sel_price  = sel_price  | sel_masked[i];
            vend_price = vend_price | vend_masked[i];
        end
    end

    // Coin front end: a lone coin is credited unless it would pass the ceiling.
    assign coin_vec   = {quarter_i, dime_i, nickle_i};
    assign coin_any   = |coin_vec;
    assign coin_multi = !$onehot0(coin_vec);
    assign coin_val   = coin_units(coin_vec);
    assign coin_sum   = SUM_W'(credit_o) + SUM_W'(coin_val);
    assign coin_ok    = coin_any && !coin_multi && (coin_sum <= SUM_W'(MAX_CREDIT));
    assign credit_upd = coin_ok ? coin_sum[CREDIT_W-1:0] : credit_o;

    // Price is checked against the credit after this cycle's coin.
    assign sel_any    = |sel_i;
    assign sel_onehot = $onehot(sel_i);
    assign afford     = credit_upd >= sel_price;
    assign remain     = credit_o - vend_price;

    always_comb begin
        state_d   = state_q;
        credit_d  = credit_o;
        item_d    = item_valid_o;
        chg_d     = 3'b000;
        reject_d  = 1'b0;
        sel_err_d = 1'b0;
        sale      = 1'b0;
        case (state_q)
            S_IDLE: begin
                reject_d  = coin_any && !coin_ok;
                credit_d  = credit_upd;
                sel_err_d = sel_any;
                if (coin_ok) state_d = S_CREDIT;
            end
            S_CREDIT: begin
                reject_d = coin_any && !coin_ok;
                credit_d = credit_upd;
                if (cancel_i) begin
                    state_d = S_CHANGE;
                end else if (sel_any) begin
                    if (sel_onehot && afford) begin
                        state_d = S_VEND;
                        item_d  = sel_i;
                    end else begin
                        sel_err_d = 1'b1;
                    end
                end
            end
            S_VEND: begin
                reject_d  = coin_any;
                sel_err_d = sel_any;
                if (vend_ready_i) begin
                    // First change coin leaves on the same edge the item is taken.
                    sale     = 1'b1;
                    item_d   = '0;
                    chg_d    = pick_coin(remain);
                    credit_d = remain - coin_units(chg_d);
                    state_d  = (credit_d == '0) ? S_IDLE : S_CHANGE;
                end
            end
            S_CHANGE: begin
                reject_d  = coin_any;
                sel_err_d = sel_any;
                chg_d     = pick_coin(credit_o);
                credit_d  = credit_o - coin_units(chg_d);
                state_d   = (credit_d == '0) ? S_IDLE : S_CHANGE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= S_IDLE;
            credit_o      <= '0;
            item_valid_o  <= '0;
            chg_quarter_o <= 1'b0;
            chg_dime_o    <= 1'b0;
            chg_nickle_o  <= 1'b0;
            coin_reject_o <= 1'b0;
            sel_err_o     <= 1'b0;
            busy_o        <= 1'b0;
        end else begin
            state_q       <= state_d;
            credit_o      <= credit_d;
            item_valid_o  <= item_d;
            chg_quarter_o <= chg_d[2];
            chg_dime_o    <= chg_d[1];
            chg_nickle_o  <= chg_d[0];
            coin_reject_o <= reject_d;
            sel_err_o     <= sel_err_d;
            busy_o        <= (state_d == S_VEND) || (state_d == S_CHANGE);
        end
    end

`ifdef VEND_SALES_CNT_EN
    always_ff @(posedge clk_i) begin
        if (rst_i)     sales_cnt_o <= '0;
        else if (sale) sales_cnt_o <= sales_cnt_o + 16'd1;
    end
`endif

endmodule
